filter_step_sequencer: RTL and testbench

// Stimulus controller for the emulated filter. Replaces a constant real input with a

---
 rtl/filter_step_sequencer_if.sv | 26 ++
 rtl/filter_step_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_filter_step_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_step_sequencer_if.sv
// ----------------------------------------------------------------------------
// filter_step_sequencer_if
// Step-table configuration bus between the emulation host and the filter step
// sequencer.
//   cfg_we     host -> seq   table write strobe
//   cfg_addr   host -> seq   table index
//   cfg_level  host -> seq   signed step level
//   cfg_dwell  host -> seq   step dwell in cycles
//   cfg_err    seq  -> host  1-cycle pulse: write dropped because a run is active
// ----------------------------------------------------------------------------
interface filter_step_sequencer_if #(
  parameter int WIDTH   = 18,
  parameter int N_STEPS = 8,
  parameter int DWELL_W = 16
);
  localparam int AW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  logic                    cfg_we;
  logic [AW-1:0]           cfg_addr;
  logic signed [WIDTH-1:0] cfg_level;
  logic [DWELL_W-1:0]      cfg_dwell;
  logic                    cfg_err;

  modport master (output cfg_we, cfg_addr, cfg_level, cfg_dwell, input cfg_err);
  modport slave  (input cfg_we, cfg_addr, cfg_level, cfg_dwell, output cfg_err);
endinterface

// File: rtl/filter_step_sequencer.sv
// ----------------------------------------------------------------------------
// filter_step_sequencer
// Stimulus controller for the emulated filter: plays a programmable table of
// step levels / dwell times onto the filter input v_in, holds the filter in
// reset before each run, and captures v_out on the last cycle of every step.
//
// Ports
//   clk        emulator clock
//   rst        asynchronous active-low reset (clears table too)
//   cfg        step-table write bus (slave side), cfg_err back to host
//   num_steps  steps to run, sampled on start
//   start      begin a sequence (level-sensitive, IDLE only)
//   abort      terminate a running sequence
//   v_out      filter output
//   v_in       filter input (registered)
//   filt_rst   active-high filter reset
//   busy       high in FLUSH/RUN
//   done       1-cycle pulse on completion (or on a rejected start)
//   step_idx   current step
//   cap_valid  1-cycle pulse: cap_data holds the end-of-step sample
//   cap_data   v_out captured on the last dwell cycle
//
// Build option
//   FILTER_SEQ_LOOP_EN  defined: after the last step wrap straight back to
//                       step 0 (no flush, filter stays out of reset) until
//                       abort; done never pulses for a run.
//
// state | meaning
// IDLE  | filter held in reset, v_in=0, waiting for start
// FLUSH | filter held in reset FLUSH_CYC cycles, v_in=level[0]
// RUN   | stepping through table, filter running
// DONE  | one-cycle completion, v_in holds final level
// ----------------------------------------------------------------------------
module filter_step_sequencer #(
  parameter int WIDTH     = 18,
  parameter int N_STEPS   = 8,
  parameter int DWELL_W   = 16,
  parameter int FLUSH_CYC = 4,
  localparam int AW       = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  filter_step_sequencer_if.slave  cfg,
  input  logic [AW:0]             num_steps,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [WIDTH-1:0] v_out,
  output logic signed [WIDTH-1:0] v_in,
  output logic                    filt_rst,
  output logic                    busy,
  output logic                    done,
  output logic [AW-1:0]           step_idx,
  output logic                    cap_valid,
  output logic signed [WIDTH-1:0] cap_data
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [AW:0] NS_MAX = (AW+1)'(N_STEPS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [FW-1:0]           flush_cnt;
  logic [DWELL_W-1:0]      dwell_cnt;
  logic [AW-1:0]           last_idx;
  logic signed [WIDTH-1:0] lvl_tab [N_STEPS];
  logic [DWELL_W-1:0]      dw_tab  [N_STEPS];

  logic [AW-1:0] nxt_idx;
  logic          start_ok;

  assign nxt_idx  = step_idx + AW'(1);
  assign start_ok = (num_steps != '0) && (num_steps <= NS_MAX);

  // Down-counter preload: a dwell of 0 behaves as a single cycle.
  function automatic logic [DWELL_W-1:0] dwell_m1(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      flush_cnt   <= '0;
      dwell_cnt   <= '0;
      last_idx    <= '0;
      v_in        <= '0;
      filt_rst    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_idx    <= '0;
      cap_valid   <= 1'b0;
      cap_data    <= '0;
      cfg.cfg_err <= 1'b0;
      for (int i = 0; i < N_STEPS; i++) begin
        lvl_tab[i] <= '0;
        dw_tab[i]  <= '0;
      end
    end else begin
      done        <= 1'b0;
      cap_valid   <= 1'b0;
      cfg.cfg_err <= 1'b0;

      // Table is only writable while no run is in flight.
      if (cfg.cfg_we) begin
        if (state == S_FLUSH || state == S_RUN) begin
          cfg.cfg_err <= 1'b1;
        end else begin
          lvl_tab[cfg.cfg_addr] <= cfg.cfg_level;
          dw_tab[cfg.cfg_addr]  <= cfg.cfg_dwell;
        end
      end

      if (abort && state != S_IDLE) begin
        state    <= S_IDLE;
        v_in     <= '0;
        filt_rst <= 1'b1;
        busy     <= 1'b0;
        step_idx <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            v_in     <= '0;
            filt_rst <= 1'b1;
            busy     <= 1'b0;
            if (start) begin
              if (start_ok) begin
                state     <= S_FLUSH;
                last_idx  <= AW'(num_steps - 1'b1);
                v_in      <= lvl_tab[0];
                busy      <= 1'b1;
                step_idx  <= '0;
                flush_cnt <= FW'(FLUSH_CYC - 1);
              end else begin
                done <= 1'b1;
              end
            end
          end

          S_FLUSH: begin
            if (flush_cnt == '0) begin
              state     <= S_RUN;
              filt_rst  <= 1'b0;
              step_idx  <= '0;
              v_in      <= lvl_tab[0];
              dwell_cnt <= dwell_m1(dw_tab[0]);
            end else begin
              flush_cnt <= flush_cnt - FW'(1);
            end
          end

          S_RUN: begin
            if (dwell_cnt == '0) begin
              cap_data  <= v_out;
              cap_valid <= 1'b1;
              if (step_idx == last_idx) begin
`ifdef FILTER_SEQ_LOOP_EN
                step_idx  <= '0;
                v_in      <= lvl_tab[0];
                dwell_cnt <= dwell_m1(dw_tab[0]);
`else
                state     <= S_DONE;
                done      <= 1'b1;
                filt_rst  <= 1'b1;
                busy      <= 1'b0;
`endif
              end else begin
                // Next step loads in the same edge: no gap cycle between steps.
                step_idx  <= nxt_idx;
                v_in      <= lvl_tab[nxt_idx];
                dwell_cnt <= dwell_m1(dw_tab[nxt_idx]);
              end
            end else begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end
          end

          S_DONE: begin
            state    <= S_IDLE;
            v_in     <= '0;
            filt_rst <= 1'b1;
            step_idx <= '0;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_filter_step_sequencer.sv
module tb_filter_step_sequencer;
  localparam int WIDTH = 18, N_STEPS = 8, DWELL_W = 16, FLUSH_CYC = 4, AW = 3;
  localparam int ONE = 1 << 14;
`ifdef FILTER_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW:0] num_steps = '0;
  logic start = 1'b0, abort = 1'b0;
  logic signed [WIDTH-1:0] v_out, v_in, cap_data;
  logic filt_rst, busy, done, cap_valid;
  logic [AW-1:0] step_idx;

  filter_step_sequencer_if #(.WIDTH(WIDTH), .N_STEPS(N_STEPS), .DWELL_W(DWELL_W)) cfg_if ();

  filter_step_sequencer #(.WIDTH(WIDTH), .N_STEPS(N_STEPS), .DWELL_W(DWELL_W),
                          .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst), .cfg(cfg_if), .num_steps(num_steps), .start(start),
    .abort(abort), .v_out(v_out), .v_in(v_in), .filt_rst(filt_rst), .busy(busy),
    .done(done), .step_idx(step_idx), .cap_valid(cap_valid), .cap_data(cap_data));

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  // v_out source: distinct per-cycle pattern, or a simple first-order filter.
  function automatic int pat(input int n);
    logic [WIDTH-1:0] b;
    b = WIDTH'(n * 40503 + 977);
    return int'($signed(b));
  endfunction

  bit vmode = 1'b0;
  logic signed [WIDTH-1:0] fy;
  int fdi, fst;
  always @(posedge clk or negedge rst) begin
    if (!rst) fy <= '0;
    else if (filt_rst) fy <= '0;
    else begin
      fdi = v_in - fy;
      fst = fdi >>> 3;
      if (fst == 0 && fdi != 0) fst = (fdi > 0) ? 1 : -1;
      fy <= fy + WIDTH'(fst);
    end
  end
  assign v_out = vmode ? fy : WIDTH'(pat(edge_no));

  function automatic real fref(input int lvl, input int k);
    real y = 0.0;
    for (int i = 0; i < k; i++) y = y + (real'(lvl) - y) / 8.0;
    return y;
  endfunction

  // ---------------- reference model ----------------
  int tlv [N_STEPS];
  int tdw [N_STEPS];
  bit run_on = 1'b0;
  int run_s, run_n, run_tot, run_end;
  int rlv [N_STEPS];
  int rdw [N_STEPS];

  typedef struct {
    int  e;
    int  data;
    bit  approx;
    real ref_v;
  } cap_t;
  cap_t cap_q[$];
  int   done_q[$];
  int   err_q[$];

  int checks = 0, errors = 0;

  function automatic void chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", nm, edge_no, act, exp);
    end
  endfunction

  function automatic void flag(input string nm, input int e);
    checks++;
    errors++;
    $display("FAIL %s: event expected at edge %0d, seen at edge %0d", nm, e, edge_no);
  endfunction

  // Expected outputs for the cycle following edge n, from the run timeline.
  function automatic void exp_at(input int n, output int ev, output bit ef, output bit eb,
                                 output int es, output bit esv);
    int t, r, acc;
    ev = 0; ef = 1'b1; eb = 1'b0; es = 0; esv = 1'b0;
    if (!run_on || n < run_s || n >= run_end) return;
    t = n - run_s;
    if (t < FLUSH_CYC) begin
      ev = rlv[0]; eb = 1'b1;
      return;
    end
    r = t - FLUSH_CYC;
    if (LOOP) r = r % run_tot;
    if (r < run_tot) begin
      acc = 0;
      for (int k = 0; k < run_n; k++) begin
        if (r < acc + rdw[k]) begin
          ev = rlv[k]; ef = 1'b0; eb = 1'b1; es = k; esv = 1'b1;
          return;
        end
        acc += rdw[k];
      end
    end else if (r == run_tot) begin
      ev = rlv[run_n-1];
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    int n, ev, es;
    bit ef, eb, esv;
    cap_t c;
    n = edge_no;
    exp_at(n, ev, ef, eb, es, esv);
    chk(int'(v_in) == ev, "v_in", int'(v_in), ev);
    chk(filt_rst == ef, "filt_rst", int'(filt_rst), int'(ef));
    chk(busy == eb, "busy", int'(busy), int'(eb));
    if (esv) chk(int'(step_idx) == es, "step_idx", int'(step_idx), es);

    while (cap_q.size() > 0 && cap_q[0].e < n) begin flag("cap_valid_missing", cap_q[0].e); void'(cap_q.pop_front()); end
    while (done_q.size() > 0 && done_q[0] < n) begin flag("done_missing", done_q[0]); void'(done_q.pop_front()); end
    while (err_q.size() > 0 && err_q[0] < n) begin flag("cfg_err_missing", err_q[0]); void'(err_q.pop_front()); end

    if (cap_valid) begin
      if (cap_q.size() == 0 || cap_q[0].e != n) flag("cap_valid_spurious", (cap_q.size() > 0) ? cap_q[0].e : -1);
      else begin
        c = cap_q.pop_front();
        if (c.approx)
          chk((real'(int'(cap_data)) - c.ref_v <= 1.0) && (c.ref_v - real'(int'(cap_data)) <= 1.0),
              "cap_data_steady", int'(cap_data), int'(c.ref_v));
        else
          chk(int'(cap_data) == c.data, "cap_data", int'(cap_data), c.data);
      end
    end
    if (done) begin
      if (done_q.size() == 0 || done_q[0] != n) flag("done_spurious", (done_q.size() > 0) ? done_q[0] : -1);
      else begin chk(1'b1 == done, "done", int'(done), 1); void'(done_q.pop_front()); end
    end
    if (cfg_if.cfg_err) begin
      if (err_q.size() == 0 || err_q[0] != n) flag("cfg_err_spurious", (err_q.size() > 0) ? err_q[0] : -1);
      else begin chk(1'b1 == cfg_if.cfg_err, "cfg_err", int'(cfg_if.cfg_err), 1); void'(err_q.pop_front()); end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int lv, input int dw);
    cfg_if.cfg_we    = 1'b1;
    cfg_if.cfg_addr  = AW'(a);
    cfg_if.cfg_level = WIDTH'(lv);
    cfg_if.cfg_dwell = DWELL_W'(dw);
    wait_edge();
    cfg_if.cfg_we = 1'b0;
    tlv[a] = lv;
    tdw[a] = dw;
  endtask

  task automatic rand_table(input int max_dw);
    for (int i = 0; i < N_STEPS; i++)
      cfg_write(i, int'($signed(WIDTH'($urandom))), int'($urandom_range(0, max_dw)));
  endtask

  // abort_at / poke_at / rst_at are relative to the start-sampling edge S.
  // poke_at = -2 picks a random in-run poke; -1 disables it.
  task automatic run_seq(input int n, input int abort_at, input int poke_at, input int rst_at);
    int s, a, tot, e, k, lim;
    bit did_rst;
    cap_t c;
    tot = 0;
    did_rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      rlv[i] = tlv[i];
      rdw[i] = (tdw[i] == 0) ? 1 : tdw[i];
      tot += rdw[i];
    end
    if (LOOP && abort_at == 0 && rst_at < 0) abort_at = FLUSH_CYC + 2 * tot + 1;
    if (poke_at == -2) poke_at = int'($urandom_range(0, FLUSH_CYC + tot - 2));
    num_steps = (AW+1)'(n);
    start = 1'b1;
    s = edge_no + 1;
    a = (abort_at > 0) ? s + abort_at : 32'h7fff_ffff;
    run_s = s; run_n = n; run_tot = tot; run_end = a; run_on = 1'b1;
    e = s + FLUSH_CYC;
    k = 0;
    while (LOOP || k < n) begin
      e += rdw[k % n];
      if (e >= a) break;
      c.e = e;
      c.data = pat(e - 1);
      c.approx = vmode;
      c.ref_v = vmode ? fref(rlv[0], e - 1 - s - FLUSH_CYC) : 0.0;
      cap_q.push_back(c);
      k++;
    end
    if (!LOOP && s + FLUSH_CYC + tot < a) done_q.push_back(s + FLUSH_CYC + tot);
    wait_edge();
    start = 1'b0;
    lim = (abort_at > 0) ? abort_at : FLUSH_CYC + tot + 2;
    for (int r = 0; r < lim; r++) begin
      if (r == poke_at) begin
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_addr  = AW'($urandom);
        cfg_if.cfg_level = WIDTH'($urandom);
        cfg_if.cfg_dwell = DWELL_W'($urandom_range(1, 9));
        start = 1'b1;
        err_q.push_back(s + r + 1);
      end else if (r == poke_at + 1) begin
        cfg_if.cfg_we = 1'b0;
        start = 1'b0;
      end
      if (r == rst_at) begin
        #2;
        rst = 1'b0;
        run_on = 1'b0;
        cap_q.delete();
        done_q.delete();
        err_q.delete();
        for (int i = 0; i < N_STEPS; i++) begin tlv[i] = 0; tdw[i] = 0; end
        #1;
        chk(int'(v_in) == 0, "rst_v_in", int'(v_in), 0);
        chk(filt_rst == 1'b1, "rst_filt_rst", int'(filt_rst), 1);
        chk(busy == 1'b0, "rst_busy", int'(busy), 0);
        chk(cap_valid == 1'b0, "rst_cap_valid", int'(cap_valid), 0);
        did_rst = 1'b1;
        break;
      end
      if (abort_at > 0 && r == abort_at - 1) abort = 1'b1;
      wait_edge();
    end
    abort = 1'b0;
    start = 1'b0;
    cfg_if.cfg_we = 1'b0;
    if (did_rst) begin
      wait_edge();
      wait_edge();
      rst = 1'b1;
      wait_edge();
    end
  endtask

  task automatic bad_start(input int n);
    num_steps = (AW+1)'(n);
    start = 1'b1;
    done_q.push_back(edge_no + 1);
    wait_edge();
    start = 1'b0;
    wait_edge();
    wait_edge();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_if.cfg_we = 1'b0;
    cfg_if.cfg_addr = '0;
    cfg_if.cfg_level = '0;
    cfg_if.cfg_dwell = '0;
    for (int i = 0; i < N_STEPS; i++) begin tlv[i] = 0; tdw[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk(int'(v_in) == 0, "reset_v_in", int'(v_in), 0);
    chk(filt_rst == 1'b1, "reset_filt_rst", int'(filt_rst), 1);
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    chk(done == 1'b0, "reset_done", int'(done), 0);
    chk(int'(step_idx) == 0, "reset_step_idx", int'(step_idx), 0);
    chk(cap_valid == 1'b0, "reset_cap_valid", int'(cap_valid), 0);
    chk(int'(cap_data) == 0, "reset_cap_data", int'(cap_data), 0);
    chk(cfg_if.cfg_err == 1'b0, "reset_cfg_err", int'(cfg_if.cfg_err), 0);
    rst = 1'b1;
    wait_edge();

    // Reset-cleared table: every step plays level 0 for one cycle.
    run_seq(N_STEPS, 0, -1, -1);

    // Levels {+1.0,-0.5,0}, dwells {10,5,0}.
    cfg_write(0, ONE, 10);
    cfg_write(1, -ONE / 2, 5);
    cfg_write(2, 0, 0);
    run_seq(3, 0, -1, -1);

    // Abort on cycle 3 of step 1, then abort during FLUSH, then abort in IDLE.
    cfg_write(0, 1234, 6);
    cfg_write(1, -777, 8);
    cfg_write(2, 55, 4);
    run_seq(3, FLUSH_CYC + 6 + 4, -1, -1);
    run_seq(3, 2, -1, -1);
    abort = 1'b1;
    wait_edge();
    abort = 1'b0;
    wait_edge();

    // Writes/starts while busy are dropped; the following run proves the table survived.
    run_seq(3, 0, FLUSH_CYC + 2, -1);
    run_seq(3, 0, 1, -1);
    run_seq(3, 0, -1, -1);

    // Rejected starts.
    bad_start(0);
    bad_start(N_STEPS + 1);

    // Randomized tables and lengths.
    for (int it = 0; it < 10; it++) begin
      rand_table(12);
      run_seq(int'($urandom_range(1, N_STEPS)), 0, ($urandom_range(0, 1) != 0) ? -2 : -1, -1);
    end

    // Loop-style table: 2 steps, dwell 3 (single pass unless looping is built in).
    cfg_write(0, 3000, 3);
    cfg_write(1, -3000, 3);
    run_seq(2, LOOP ? FLUSH_CYC + 6 * 3 + 1 : 0, -1, -1);

    // Async reset mid-RUN, then a run on the cleared table.
    rand_table(9);
    run_seq(4, 0, -1, FLUSH_CYC + 5);
    run_seq(4, 0, -1, -1);

    // Constant 1.0 into the filter, dwell 1000: capture must sit at steady state.
    cfg_write(0, ONE, 1000);
    vmode = 1'b1;
    run_seq(1, 0, -1, -1);
    vmode = 1'b0;

    repeat (4) wait_edge();
    chk(cap_q.size() == 0, "cap_queue_drained", cap_q.size(), 0);
    chk(done_q.size() == 0, "done_queue_drained", done_q.size(), 0);
    chk(err_q.size() == 0, "err_queue_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
